// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//   Single-clock SPI master that builds the {cmd[1:0], payload} frames consumed
//   by the SPI slave/RAM wrapper. Each transaction carries one host command:
//   write-address (00), write-data (01), read-address (10) or read-data (11).
//   The frame is sent MSB first on MOSI while SS_n is low. For read-data the
//   block waits RD_LATENCY cycles and then captures a DATA_W-bit reply from
//   MISO, MSB first.
//
//   Optional feature macro: SPI_MASTER_SEQ_CHK_EN
//     When defined, a read-data start is only accepted if the last completed
//     frame was a read-address. A rejected start sends no frame and pulses
//     seq_err for one cycle.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   transaction request, sampled only while idle
//   cmd       in   2-bit command, latched on acceptance
//   tx_data   in   DATA_W payload, latched on acceptance
//   busy      out  high from acceptance until the end of the SS_n gap
//   done      out  one-cycle pulse when SS_n returns high
//   rx_data   out  last captured read-data byte
//   rx_valid  out  one-cycle pulse together with done, read-data only
//   SS_n      out  slave select, active low
//   MOSI      out  serial data to slave, MSB first
//   MISO      in   serial data from slave, MSB first
//   seq_err   out  (SPI_MASTER_SEQ_CHK_EN only) rejected read-data pulse
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
`ifdef SPI_MASTER_SEQ_CHK_EN
  ,
  output logic              seq_err
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEL     = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_WAIT_RD = 3'd3;
  localparam logic [2:0] ST_RECV    = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;
  localparam logic [2:0] ST_GAP     = 3'd6;

  // The shift register carries the read/write select bit followed by the
  // full frame, so the select bit appears first and then the frame itself.
  localparam int SH_W = DATA_W + 3;

  localparam logic [7:0] SH_CNT   = 8'(SH_W);
  localparam logic [7:0] RD_CNT   = 8'(RD_LATENCY);
  localparam logic [7:0] DATA_CNT = 8'(DATA_W);
  localparam logic [7:0] GAP_CNT  = 8'(GAP_CYCLES);

  logic [2:0]        state_r;
  logic [7:0]        cnt_r;
  logic [SH_W-1:0]   sh_r;
  logic [DATA_W-1:0] rx_sh_r;
  logic [1:0]        cmd_r;
  logic              ss_n_r;
  logic              mosi_r;
  logic              busy_r;
  logic              done_r;
  logic              rx_valid_r;
  logic [DATA_W-1:0] rx_data_r;

  logic [2:0]        state_nxt_s;
  logic [7:0]        cnt_nxt_s;
  logic [SH_W-1:0]   sh_nxt_s;
  logic [DATA_W-1:0] rx_sh_nxt_s;
  logic [1:0]        cmd_nxt_s;
  logic              mosi_nxt_s;
  logic              done_nxt_s;
  logic              rx_valid_nxt_s;
  logic [DATA_W-1:0] rx_data_nxt_s;
  logic              ss_n_nxt_s;
  logic              busy_nxt_s;
  logic              reject_s;
  logic              is_rd_s;

  assign is_rd_s = (cmd_r == 2'b11);

`ifdef SPI_MASTER_SEQ_CHK_EN
  logic rd_addr_seen_r;
  logic seq_err_r;

  assign reject_s = (cmd == 2'b11) & ~rd_addr_seen_r;
  assign seq_err  = seq_err_r;

  // Sequence flag and rejection pulse for read-data without a preceding read-address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_seen_r <= 1'b0;
      seq_err_r      <= 1'b0;
    end else begin
      seq_err_r <= (state_r == ST_IDLE) & start & reject_s;
      if (done_nxt_s) begin
        rd_addr_seen_r <= (cmd_r == 2'b10);
      end else begin
        rd_addr_seen_r <= rd_addr_seen_r;
      end
    end
  end
`else
  assign reject_s = 1'b0;
`endif

  // Next-state and next-output computation; outputs reflect the state being entered
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    sh_nxt_s       = sh_r;
    rx_sh_nxt_s    = rx_sh_r;
    cmd_nxt_s      = cmd_r;
    mosi_nxt_s     = 1'b0;
    done_nxt_s     = 1'b0;
    rx_valid_nxt_s = 1'b0;
    rx_data_nxt_s  = rx_data_r;

    case (state_r)
      ST_IDLE: begin
        if (start && !reject_s) begin
          state_nxt_s = ST_SEL;
          cnt_nxt_s   = 8'd0;
          sh_nxt_s    = {cmd[1], cmd, tx_data};
          cmd_nxt_s   = cmd;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_SEL: begin
        state_nxt_s = ST_SHIFT;
        mosi_nxt_s  = sh_r[SH_W-1];
        sh_nxt_s    = {sh_r[SH_W-2:0], 1'b0};
        cnt_nxt_s   = 8'd1;
      end

      ST_SHIFT: begin
        if (cnt_r == SH_CNT) begin
          if (is_rd_s) begin
            if (RD_LATENCY == 0) begin
              // No turnaround: the first reply bit is taken right away.
              state_nxt_s = ST_RECV;
              rx_sh_nxt_s = {rx_sh_r[DATA_W-2:0], MISO};
              cnt_nxt_s   = 8'd1;
            end else begin
              state_nxt_s = ST_WAIT_RD;
              cnt_nxt_s   = 8'd1;
            end
          end else begin
            state_nxt_s = ST_HOLD;
            cnt_nxt_s   = 8'd0;
          end
        end else begin
          mosi_nxt_s = sh_r[SH_W-1];
          sh_nxt_s   = {sh_r[SH_W-2:0], 1'b0};
          cnt_nxt_s  = cnt_r + 8'd1;
        end
      end

      ST_WAIT_RD: begin
        if (cnt_r == RD_CNT) begin
          // MISO is sampled on the edge that enters each RECV cycle.
          state_nxt_s = ST_RECV;
          rx_sh_nxt_s = {rx_sh_r[DATA_W-2:0], MISO};
          cnt_nxt_s   = 8'd1;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end

      ST_RECV: begin
        if (cnt_r == DATA_CNT) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = 8'd0;
        end else begin
          rx_sh_nxt_s = {rx_sh_r[DATA_W-2:0], MISO};
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end

      ST_HOLD: begin
        state_nxt_s    = ST_GAP;
        done_nxt_s     = 1'b1;
        rx_valid_nxt_s = is_rd_s;
        cnt_nxt_s      = 8'd1;
        if (is_rd_s) begin
          rx_data_nxt_s = rx_sh_r;
        end else begin
          rx_data_nxt_s = rx_data_r;
        end
      end

      ST_GAP: begin
        if (cnt_r >= GAP_CNT) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase

    ss_n_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_GAP);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 8'd0;
      sh_r       <= '0;
      rx_sh_r    <= '0;
      cmd_r      <= 2'b00;
      ss_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_data_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      sh_r       <= sh_nxt_s;
      rx_sh_r    <= rx_sh_nxt_s;
      cmd_r      <= cmd_nxt_s;
      ss_n_r     <= ss_n_nxt_s;
      mosi_r     <= mosi_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      rx_valid_r <= rx_valid_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
    end
  end

  assign SS_n     = ss_n_r;
  assign MOSI     = mosi_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;

endmodule
